// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller: hit service, dirty write-back, line refill.
// Optional hit/miss statistics counters are enabled with `define DCACHE_STATS_EN.
module dcache_ctrl #(
    parameter int LINES      = 4,
    parameter int LINE_BYTES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic [1:0]                DC_rd_wr,
    input  logic                      DC_we,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata,
    output logic                      dCacheMiss,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [LINE_BYTES*8-1:0]   mem_wdata,
    input  logic [LINE_BYTES*8-1:0]   mem_rdata,
    input  logic                      mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]               hit_cnt,
    output logic [15:0]               miss_cnt
`endif
);

    localparam int LINE_BITS = LINE_BYTES * 8;
    localparam int IDX_W     = $clog2(LINES);
    localparam int TAG_W     = 28 - IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q;
    logic [LINES-1:0]       dirty_q;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [LINE_BITS-1:0]   data_q [LINES];
    logic [IDX_W-1:0]       miss_idx_q;
    logic [TAG_W-1:0]       miss_tag_q;

    logic [IDX_W-1:0]       req_idx;
    logic [TAG_W-1:0]       req_tag;
    logic                   hit;
    logic                   idle_hit;
    logic                   idle_miss;
    logic                   fill_done;
    logic [LINE_BITS-1:0]   hit_line;
    logic [31:0]            hit_word;
    logic [7:0]             hit_byte;
    logic [31:0]            load_data;

    assign req_idx   = addr[4 +: IDX_W];
    assign req_tag   = addr[31 -: TAG_W];
    assign hit       = req && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign idle_hit  = (state_q == IDLE) && hit;
    assign idle_miss = (state_q == IDLE) && req && !hit;
    assign fill_done = (state_q == FILL) && mem_ack;

    assign hit_line  = data_q[req_idx];
    assign hit_word  = hit_line[{addr[3:2], 5'b0} +: 32];
    assign hit_byte  = hit_line[{addr[3:0], 3'b0} +: 8];
    assign load_data = DC_rd_wr[0] ? hit_word : {{24{hit_byte[7]}}, hit_byte};

    always_comb begin
        state_d    = state_q;
        rdata      = '0;
        dCacheMiss = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (!DC_rd_wr[1]) begin
                            rdata = load_data;
                        end
                    end else begin
                        dCacheMiss = 1'b1;
                        state_d    = (valid_q[req_idx] && dirty_q[req_idx]) ? WB : FILL;
                    end
                end
            end
            WB: begin
                dCacheMiss = 1'b1;
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = {tag_q[miss_idx_q], miss_idx_q, 4'b0};
                mem_wdata  = data_q[miss_idx_q];
                if (mem_ack) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                dCacheMiss = 1'b1;
                mem_req    = 1'b1;
                mem_addr   = {miss_tag_q, miss_idx_q, 4'b0};
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Miss index/tag are captured so an in-flight transaction survives req dropping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
        end else begin
            state_q <= state_d;
            if (idle_miss) begin
                miss_idx_q <= req_idx;
                miss_tag_q <= req_tag;
            end
            if (idle_hit && DC_we) begin
                dirty_q[req_idx] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[miss_idx_q] <= 1'b1;
                dirty_q[miss_idx_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (idle_hit && DC_we) begin
                if (DC_rd_wr[0]) begin
                    data_q[req_idx][{addr[3:2], 5'b0} +: 32] <= wdata;
                end else begin
                    data_q[req_idx][{addr[3:0], 3'b0} +: 8] <= wdata[7:0];
                end
            end
            if (fill_done) begin
                data_q[miss_idx_q] <= mem_rdata;
                tag_q[miss_idx_q]  <= miss_tag_q;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (idle_hit) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (idle_miss) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: architectural memory model, scoreboarded loads,
// and a negedge memory responder with programmable ack delay.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [1:0]   DC_rd_wr;
    logic         DC_we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         dCacheMiss;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;
`ifdef DCACHE_STATS_EN
    logic [15:0]  hit_cnt;
    logic [15:0]  miss_cnt;
`endif

    always #5 clk = ~clk;

    dcache_ctrl #(.LINES(4), .LINE_BYTES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .DC_rd_wr   (DC_rd_wr),
        .DC_we      (DC_we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .dCacheMiss (dCacheMiss),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    localparam int OP_LDB = 0, OP_LDW = 1, OP_STB = 2, OP_STW = 3;

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] mem  [logic [31:0]];
    logic [127:0] arch [logic [31:0]];
    logic [31:0]  exp_q[$];
    logic [31:0]  wb_addr_q[$];
    logic [127:0] wb_data_q[$];
    logic [31:0]  fill_addr_q[$];
    int           ack_delay = 1;
    int           resp_cnt = 0;
    logic [31:0]  last_rdata;

    function automatic logic [127:0] init_line(input logic [31:0] la);
        return {la ^ 32'h5A5A_0C0C, la + 32'h0BAD_F00D, ~la, la ^ 32'h1357_9BDF};
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        if (mem.exists(la)) return mem[la];
        return init_line(la);
    endfunction

    function automatic logic [127:0] arch_line(input logic [31:0] la);
        if (arch.exists(la)) return arch[la];
        return init_line(la);
    endfunction

    function automatic logic [31:0] ref_load(input int op, input logic [31:0] a);
        logic [127:0] line;
        logic [7:0]   b;
        line = arch_line({a[31:4], 4'b0});
        if (op == OP_LDW) return line[int'(a[3:2]) * 32 +: 32];
        b = line[int'(a[3:0]) * 8 +: 8];
        return {{24{b[7]}}, b};
    endfunction

    task automatic arch_store(input int op, input logic [31:0] a, input logic [31:0] wd);
        logic [127:0] line;
        line = arch_line({a[31:4], 4'b0});
        if (op == OP_STW) line[int'(a[3:2]) * 32 +: 32] = wd;
        else              line[int'(a[3:0]) * 8 +: 8]   = wd[7:0];
        arch[{a[31:4], 4'b0}] = line;
    endtask

    // Memory responder: ack after ack_delay extra cycles of mem_req in each WB/FILL phase.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack  = 1'b0;
            resp_cnt = 0;
        end
        if (rst || !mem_req) begin
            resp_cnt = 0;
        end else if (resp_cnt >= ack_delay) begin
            mem_ack = 1'b1;
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                wb_addr_q.push_back(mem_addr);
                wb_data_q.push_back(mem_wdata);
            end else begin
                mem_rdata = mem_line(mem_addr);
                fill_addr_q.push_back(mem_addr);
            end
        end else begin
            resp_cnt++;
        end
    end

    // Called just after a rising edge; returns after the access's completing edge (+1).
    task automatic issue_access(input int op, input logic [31:0] a, input logic [31:0] wd,
                                output int stall, output int gap);
        bit done;
        logic [31:0] exp;
        req      = 1'b1;
        DC_rd_wr = op[1:0];
        DC_we    = op[1];
        addr     = a;
        wdata    = wd;
        if (op < 2) exp_q.push_back(ref_load(op, a));
        stall = 0;
        gap   = 0;
        done  = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (!dCacheMiss) done = 1'b1;
            else begin
                stall++;
                if (!mem_req) gap++;
            end
        end
        last_rdata = rdata;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL access_timeout addr=%h stall=%0d required completion", a, stall);
            if (op < 2) void'(exp_q.pop_front());
        end else if (op < 2) begin
            exp = exp_q.pop_front();
            vectors++;
            if (rdata !== exp) begin
                miscompares++;
                $display("FAIL load_data addr=%h op=%0d got=%h exp=%h", a, op, rdata, exp);
            end
        end
        @(posedge clk);
        #1;
        if (op >= 2) arch_store(op, a, wd);
    endtask

    task automatic go_idle();
        req = 1'b0; DC_rd_wr = 2'b00; DC_we = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        go_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        arch.delete();
        foreach (mem[k]) arch[k] = mem[k];
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++;
        if ({dCacheMiss, mem_req, mem_we} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b exp=000", {dCacheMiss, mem_req, mem_we});
        end
        vectors++;
        if (rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_data rdata=%h mem_addr=%h mem_wdata=%h exp=0", rdata, mem_addr, mem_wdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_cold_fill();
        int stall, gap, nf;
        ack_delay = 1;
        nf = fill_addr_q.size();
        issue_access(OP_LDW, 32'h100, 32'h0, stall, gap);
        vectors++;
        if (stall != 3 || gap != 1) begin
            miscompares++;
            $display("FAIL cold_stall got stall=%0d gap=%0d exp stall=3 gap=1", stall, gap);
        end
        vectors++;
        if (fill_addr_q.size() != nf + 1 || fill_addr_q[$] !== 32'h100) begin
            miscompares++;
            $display("FAIL cold_fill_addr got=%h exp=00000100", fill_addr_q[$]);
        end
        vectors++;
        if (last_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL cold_rdata got=%h exp=deadbeef", last_rdata);
        end
    endtask

    task automatic test_store_byte();
        int stall, gap;
        issue_access(OP_STB, 32'h101, 32'h0000_0080, stall, gap);
        vectors++;
        if (stall != 0) begin
            miscompares++;
            $display("FAIL stb_hit_stall got=%0d exp=0", stall);
        end
        issue_access(OP_LDB, 32'h101, 32'h0, stall, gap);
        vectors++;
        if (last_rdata !== 32'hFFFF_FF80 || stall != 0) begin
            miscompares++;
            $display("FAIL ldb_sext got=%h stall=%0d exp=ffffff80 stall=0", last_rdata, stall);
        end
        issue_access(OP_LDW, 32'h103, 32'h0, stall, gap);
    endtask

    task automatic test_dirty_evict();
        int stall, gap, nw;
        ack_delay = 0;
        nw = wb_addr_q.size();
        issue_access(OP_LDW, 32'h140, 32'h0, stall, gap);
        vectors++;
        if (wb_addr_q.size() != nw + 1 || wb_addr_q[$] !== 32'h100) begin
            miscompares++;
            $display("FAIL wb_addr got=%h count=%0d exp=00000100", wb_addr_q[$], wb_addr_q.size() - nw);
        end
        vectors++;
        if (wb_data_q[$][31:0] !== 32'hDEAD80EF) begin
            miscompares++;
            $display("FAIL wb_data got=%h exp=dead80ef", wb_data_q[$][31:0]);
        end
        vectors++;
        if (fill_addr_q[$] !== 32'h140) begin
            miscompares++;
            $display("FAIL evict_fill_addr got=%h exp=00000140", fill_addr_q[$]);
        end
        vectors++;
        if (stall != 3 || gap != 1) begin
            miscompares++;
            $display("FAIL dirty_stall got stall=%0d gap=%0d exp stall=3 gap=1", stall, gap);
        end
    endtask

    task automatic test_delayed_ack();
        int stall, gap, nw;
        ack_delay = 5;
        nw = wb_addr_q.size();
        issue_access(OP_LDW, 32'h200, 32'h0, stall, gap);
        vectors++;
        if (stall != 7 || gap != 1) begin
            miscompares++;
            $display("FAIL delayed_stall got stall=%0d gap=%0d exp stall=7 gap=1", stall, gap);
        end
        vectors++;
        if (wb_addr_q.size() != nw) begin
            miscompares++;
            $display("FAIL spurious_wb got=%0d exp=0", wb_addr_q.size() - nw);
        end
    endtask

    task automatic test_back_to_back();
        int stall, gap, op;
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            ack_delay = $urandom_range(0, 3);
            op = $urandom_range(0, 3);
            a  = 32'h1000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
            issue_access(op, a, $urandom, stall, gap);
            vectors++;
            if (gap != ((stall > 0) ? 1 : 0)) begin
                miscompares++;
                $display("FAIL b2b_memreq_gap addr=%h gap=%0d stall=%0d", a, gap, stall);
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid_wb();
        int stall, gap, nw;
        bit seen;
        ack_delay = 1;
        issue_access(OP_STW, 32'h010, 32'hCAFE_F00D, stall, gap);
        ack_delay = 20;
        nw = wb_addr_q.size();
        req = 1'b1; DC_rd_wr = 2'b01; DC_we = 1'b0; addr = 32'h050;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL rst_wb_entry got=0 exp=1");
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        go_idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b0 || dCacheMiss !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_abort mem_req=%b dCacheMiss=%b exp=0", mem_req, dCacheMiss);
        end
        vectors++;
        if (wb_addr_q.size() != nw) begin
            miscompares++;
            $display("FAIL rst_wb_done got=%0d exp=0", wb_addr_q.size() - nw);
        end
        @(posedge clk);
        #1;
        arch.delete();
        foreach (mem[k]) arch[k] = mem[k];
        ack_delay = 1;
        issue_access(OP_LDW, 32'h100, 32'h0, stall, gap);
        vectors++;
        if (stall != 3) begin
            miscompares++;
            $display("FAIL rst_invalidate stall=%0d exp=3", stall);
        end
        issue_access(OP_LDW, 32'h010, 32'h0, stall, gap);
        go_idle();
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        int stall, gap;
        do_reset();
        ack_delay = 1;
        issue_access(OP_LDW, 32'h300, 32'h0, stall, gap);
        issue_access(OP_LDW, 32'h310, 32'h0, stall, gap);
        issue_access(OP_LDW, 32'h300, 32'h0, stall, gap);
        go_idle();
        @(negedge clk);
        vectors++;
        if (hit_cnt !== 16'd3 || miss_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL stats_count hit=%0d miss=%0d exp hit=3 miss=2", hit_cnt, miss_cnt);
        end
        @(posedge clk);
        #1;
        req = 1'b1; DC_rd_wr = 2'b01; addr = 32'h300;
        repeat (65532) @(posedge clk);
        #1;
        go_idle();
        @(negedge clk);
        vectors++;
        if (hit_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL stats_preload hit=%h exp=ffff", hit_cnt);
        end
        @(posedge clk);
        #1;
        req = 1'b1; DC_rd_wr = 2'b01; addr = 32'h300;
        @(posedge clk);
        #1;
        go_idle();
        @(negedge clk);
        vectors++;
        if (hit_cnt !== 16'h0000 || miss_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL stats_wrap hit=%h miss=%0d exp hit=0000 miss=2", hit_cnt, miss_cnt);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        logic [127:0] l100;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        l100 = init_line(32'h100);
        l100[31:0] = 32'hDEADBEEF;
        mem[32'h100] = l100;
        test_reset();
        test_cold_fill();
        test_store_byte();
        test_dirty_evict();
        test_delayed_ack();
        test_back_to_back();
        test_reset_mid_wb();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
